// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: enable/acknowledge strobe and received byte.
interface uart_rx_if;
    logic       go;
    logic [7:0] data;
    logic       data_ready;

    modport master (input go, output data, output data_ready);
    modport slave  (output go, input data, input data_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error lockout and a go/data_ready
// consumer handshake. BitTicks = ClockFrequencyHz / BaudRate must be at least 4.
module uart_rx #(
    parameter int ClockFrequencyHz = 30_000_000,
    parameter int BaudRate         = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int BitTicks  = ClockFrequencyHz / BaudRate;
    localparam int HalfTicks = BitTicks / 2;
    localparam int CntW      = (BitTicks > 2) ? $clog2(BitTicks) : 2;

    localparam logic [CntW-1:0] CntZero  = {CntW{1'b0}};
    localparam logic [CntW-1:0] CntOne   = CntW'(1'b1);
    localparam logic [CntW-1:0] BitLast  = CntW'(BitTicks - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfTicks - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r;
    logic [CntW-1:0] cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      data_r;
    logic            data_ready_r;
    logic            armed_r;
    logic            sync1_r;
    logic            sync2_r;
    logic            rxs_s;

    assign rxs_s          = sync2_r;
    assign bus.data       = data_r;
    assign bus.data_ready = data_ready_r;

    // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Receive FSM: armed_r blocks a restart until the line has been seen high,
    // so a framing error or a reset mid-frame cannot retrigger on a held-low line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CntZero;
            bit_idx_r    <= 3'd0;
            data_r       <= 8'h00;
            data_ready_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_ready_r <= 1'b0;
                    if (rxs_s) begin
                        armed_r <= 1'b1;
                    end else if (go_ok(bus.go, armed_r)) begin
                        state_r <= ST_START;
                        cnt_r   <= CntZero;
                    end
                end
                ST_START: begin
                    if (!bus.go) begin
                        state_r      <= ST_IDLE;
                        data_ready_r <= 1'b0;
                    end else if (cnt_r == HalfLast) begin
                        cnt_r     <= CntZero;
                        bit_idx_r <= 3'd0;
                        state_r   <= rxs_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                ST_DATA: begin
                    if (!bus.go) begin
                        state_r      <= ST_IDLE;
                        data_ready_r <= 1'b0;
                    end else if (cnt_r == BitLast) begin
                        cnt_r  <= CntZero;
                        data_r <= {rxs_s, data_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                ST_STOP: begin
                    if (!bus.go) begin
                        state_r      <= ST_IDLE;
                        data_ready_r <= 1'b0;
                    end else if (cnt_r == BitLast) begin
                        cnt_r <= CntZero;
                        if (rxs_s) begin
                            state_r      <= ST_DONE;
                            data_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            armed_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CntOne;
                    end
                end
                ST_DONE: begin
                    if (!bus.go) begin
                        state_r      <= ST_IDLE;
                        data_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= CntZero;
                    data_ready_r <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic go_ok(input logic go_v, input logic armed_v);
        return go_v & armed_v;
    endfunction
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at BitTicks=8, HalfTicks=4.
module tb_uart_rx;
    localparam int BitT  = 8;
    localparam int HalfT = 4;
    // rx -> rxs adds two cycles ahead of the 77-cycle receive latency.
    localparam int RiseOffset = 2 + HalfT + 9 * BitT + 1;

    typedef struct {
        logic [7:0] val;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev_ready = 1'b0;
    exp_t sb_q[$];

    uart_rx_if bus();

    uart_rx #(
        .ClockFrequencyHz(1_000_000),
        .BaudRate        (125_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every rising data_ready must match the oldest expected byte and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.data_ready === 1'b1 && prev_ready !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rx_data", {24'd0, bus.data}, {24'd0, e.val});
                check("rx_latency", cyc, e.due);
            end
        end
        prev_ready <= bus.data_ready;
    end

    // Serialise one frame LSB first; rst_bit >= 0 pulses reset mid data bit rst_bit and abandons the frame.
    task automatic send_frame(input logic [7:0] v, input logic stop, input int rst_bit);
        logic [9:0] f;
        f = {stop, v, 1'b0};
        if (stop && rst_bit < 0) sb_q.push_back('{v, cyc + RiseOffset});
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (rst_bit >= 0 && i == rst_bit + 1) begin
                repeat (BitT / 2) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                rx  = 1'b1;
                repeat (3 * BitT) @(posedge clk);
                #1;
                return;
            end
            repeat (BitT) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic ack(input string nm);
        repeat (6) @(posedge clk);
        #1;
        check({nm, "_hold"}, {31'd0, bus.data_ready}, 32'd1);
        bus.go = 1'b0;
        @(posedge clk);
        #1;
        bus.go = 1'b1;
        check({nm, "_ack"}, {31'd0, bus.data_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        rst    = 1'b1;
        rx     = 1'b1;
        bus.go = 1'b0;
        idle(3);
        check("reset_data", {24'd0, bus.data}, 32'h0);
        check("reset_ready", {31'd0, bus.data_ready}, 32'd0);
        rst    = 1'b0;
        bus.go = 1'b1;
        idle(100);
        check("idle_data", {24'd0, bus.data}, 32'h0);
        check("idle_ready", {31'd0, bus.data_ready}, 32'd0);

        send_frame(8'h55, 1'b1, -1);
        ack("b55");
        send_frame(8'hA3, 1'b1, -1);
        ack("bA3");

        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(20);
        check("glitch_ready", {31'd0, bus.data_ready}, 32'd0);
        send_frame(8'h0F, 1'b1, -1);
        ack("b0F");

        send_frame(8'hFF, 1'b0, -1);
        idle(20);
        check("framing_ready", {31'd0, bus.data_ready}, 32'd0);
        send_frame(8'h81, 1'b1, -1);
        ack("b81");

        send_frame(8'h3C, 1'b1, 3);
        check("midreset_data", {24'd0, bus.data}, 32'h0);
        check("midreset_ready", {31'd0, bus.data_ready}, 32'd0);
        send_frame(8'hC3, 1'b1, -1);
        ack("bC3");

        for (int k = 0; k < 20; k++) begin
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                send_frame(v, 1'b0, -1);
                idle(20);
                check("rand_framing_ready", {31'd0, bus.data_ready}, 32'd0);
            end else begin
                send_frame(v, 1'b1, -1);
                ack("rand");
            end
            idle($urandom_range(1, 15));
        end

        idle(20);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
